branch_resolver_unit: RTL and testbench
=======================================

Name: branch_resolver_unit

Overview:
- Parametrised, registered successor to the combinational branch resolver in the ISSUE stage.
- Resolves the full RV32I conditional branch set plus JAL/JALR and computes the corrected next PC and the link value.
- Flags mispredictions against the fetch-stage prediction and owns a 2-bit-counter branch history table (BHT) that fetch reads combinationally.
- Sits between ISSUE and the PC mux, with a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, register operand width.
- ADDR_WIDTH, 32, PC/target width; must be <= DATA_WIDTH.
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, >= 2.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  operation present on the inputs
- ready_out  output  1  unit can accept an operation
- pc_in  input  ADDR_WIDTH  PC of the operation
- rs1_data_in  input  DATA_WIDTH  R[rs1]
- rs2_data_in  input  DATA_WIDTH  R[rs2]
- imm_in  input  ADDR_WIDTH  sign-extended immediate
- sel_in  input  3  functional-unit select; 3'b011 = branch unit
- uop_in  input  4  branch uOP
- pred_taken_in  input  1  fetch prediction for this operation
- valid_out  output  1  result register holds a result
- ready_in  input  1  downstream consumes the result
- pc_mux_sel_out  output  2  2'b01 = taken, 2'b10 = sequential
- target_out  output  ADDR_WIDTH  correct next PC
- link_out  output  ADDR_WIDTH  pc+4 for JAL/JALR, else 0
- mispredict_out  output  1  resolved direction differs from prediction
- bht_pc_in  input  ADDR_WIDTH  fetch lookup PC
- bht_taken_out  output  1  MSB of the indexed counter
- branch_cnt_out  output  CNT_WIDTH  resolved conditional branches
- mispredict_cnt_out  output  CNT_WIDTH  mispredictions

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low (rst_n_in).
- Reset values:
  - valid_out = 0, pc_mux_sel_out = 2'b10.
  - target_out, link_out, mispredict_out = 0.
  - Both statistics counters = 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
- Reset mid-operation discards any held result. No partial BHT update is permitted.
- uOP decode, valid only when sel_in = 3'b011:
  - 0000 BEQ, 0001 BNE.
  - 0100 BLT, 0101 BGE (signed).
  - 0110 BLTU, 0111 BGEU (unsigned).
  - 1000 JAL, 1001 JALR (always taken).
  - Any other uOP: not taken, no BHT update, no count.
- Non-branch operations (sel_in != 3'b011) are still accepted and resolve as not taken. mispredict = pred_taken_in. No BHT update, no count.
- Targets (all arithmetic modulo 2^ADDR_WIDTH, wrap-around with no flag):
  - Branch and JAL target = pc_in + imm_in.
  - JALR target = (rs1_data_in[ADDR_WIDTH-1:0] + imm_in) with bit 0 cleared.
  - target_out = taken ? computed target : pc_in + 4.
- Handshake:
  - An operation is accepted when valid_in && ready_out.
  - ready_out = !valid_out || ready_in.
  - Latency is 1 cycle: the result is registered on the accepting edge.
  - While valid_out && !ready_in, all outputs hold stable.
  - Back-to-back acceptance is allowed (throughput 1/cycle).
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - On acceptance of a conditional branch (0000–0111), the indexed counter increments if taken, else decrements, saturating at 2'b11 and 2'b00.
  - bht_taken_out is combinational from the current array.
  - A same-cycle lookup and update of the same index returns the pre-update value; there is no bypass.
- Counters:
  - branch_cnt_out increments on each accepted conditional branch.
  - mispredict_cnt_out increments on each accepted operation with mispredict.
  - Both saturate at all-ones.

Test Plan:
- Reset: drive rst_n_in low mid-stall with valid_out = 1 → valid_out = 0 immediately (asynchronously). After release, bht_taken_out = 0 for every index and both counts = 0.
- BEQ, pc = 0x100, imm = 0x20, rs1 = rs2 = 5, pred = 0 → next cycle: valid_out = 1, sel = 01, target = 0x120, mispredict = 1, branch_cnt = 1, mispredict_cnt = 1.
- BLT vs BLTU, rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x40, imm = 8:
  - BLT → sel = 01, target = 0x48.
  - BLTU → sel = 10, target = 0x44.
- JALR, rs1 = 0x1003, imm = 0x4, pc = 0x200 → target = 0x1006, link = 0x204, sel = 01, no BHT change (index 0 stays 01).
- BHT saturation at pc = 0x10 (index 4):
  - Three taken BNEs → bht_taken_out reads 0 until the first update edge, then 1 afterwards.
  - Counter sits at 11 after the third update.
  - One not-taken → counter 10, still predicts taken.
- Stall: ready_in = 0 with valid_in held high → ready_out = 0 and outputs stable for 3 cycles. Then ready_in = 1 → the next operation is accepted in the same cycle, and its result appears the following cycle.

Source files
------------

// File: rtl/branch_resolver_unit_if.sv
// Issue-side and PC-mux-side signal bundle for the branch resolver, plus the
// fetch BHT lookup port and statistics outputs.
interface branch_resolver_unit_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
);
   // issue side
   logic                  valid_in;
   logic                  ready_out;
   logic [ADDR_WIDTH-1:0] pc_in;
   logic [DATA_WIDTH-1:0] rs1_data_in;
   logic [DATA_WIDTH-1:0] rs2_data_in;
   logic [ADDR_WIDTH-1:0] imm_in;
   logic [2:0]            sel_in;
   logic [3:0]            uop_in;
   logic                  pred_taken_in;

   // result side
   logic                  valid_out;
   logic                  ready_in;
   logic [1:0]            pc_mux_sel_out;
   logic [ADDR_WIDTH-1:0] target_out;
   logic [ADDR_WIDTH-1:0] link_out;
   logic                  mispredict_out;

   // fetch lookup and statistics
   logic [ADDR_WIDTH-1:0] bht_pc_in;
   logic                  bht_taken_out;
   logic [CNT_WIDTH-1:0]  branch_cnt_out;
   logic [CNT_WIDTH-1:0]  mispredict_cnt_out;

   modport master (
      output valid_in, pc_in, rs1_data_in, rs2_data_in, imm_in, sel_in, uop_in,
             pred_taken_in, ready_in, bht_pc_in,
      input  ready_out, valid_out, pc_mux_sel_out, target_out, link_out,
             mispredict_out, bht_taken_out, branch_cnt_out, mispredict_cnt_out
   );

   modport slave (
      input  valid_in, pc_in, rs1_data_in, rs2_data_in, imm_in, sel_in, uop_in,
             pred_taken_in, ready_in, bht_pc_in,
      output ready_out, valid_out, pc_mux_sel_out, target_out, link_out,
             mispredict_out, bht_taken_out, branch_cnt_out, mispredict_cnt_out
   );
endinterface

// File: rtl/branch_resolver_unit.sv
// Registered RV32I branch/jump resolver with misprediction flagging, a 2-bit
// counter BHT read combinationally by fetch, and saturating statistics.
module branch_resolver_unit #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BHT_ENTRIES = 16,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input logic                    clk_in,
   input logic                    rst_n_in,
   branch_resolver_unit_if.slave  brif
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [2:0] SEL_BRU   = 3'b011;
   localparam logic [3:0] UOP_BEQ   = 4'b0000;
   localparam logic [3:0] UOP_BNE   = 4'b0001;
   localparam logic [3:0] UOP_BLT   = 4'b0100;
   localparam logic [3:0] UOP_BGE   = 4'b0101;
   localparam logic [3:0] UOP_BLTU  = 4'b0110;
   localparam logic [3:0] UOP_BGEU  = 4'b0111;
   localparam logic [3:0] UOP_JAL   = 4'b1000;
   localparam logic [3:0] UOP_JALR  = 4'b1001;
   localparam logic [1:0] MUX_TAKEN = 2'b01;
   localparam logic [1:0] MUX_SEQ   = 2'b10;
   localparam logic [1:0] CTR_INIT  = 2'b01;

   logic                  valid_q, valid_d;
   logic [1:0]            sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] target_q, target_d;
   logic [ADDR_WIDTH-1:0] link_q, link_d;
   logic                  mispred_q, mispred_d;
   logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
   logic [1:0]            bht_q [BHT_ENTRIES];
   logic [1:0]            bht_d [BHT_ENTRIES];

   logic                  ready_c;
   logic                  accept_c;
   logic                  is_cond_c;
   logic                  is_jump_c;
   logic                  is_jalr_c;
   logic                  taken_c;
   logic                  mispred_c;
   logic                  lt_s_c;
   logic                  lt_u_c;
   logic                  eq_c;
   logic [ADDR_WIDTH-1:0] seq_pc_c;
   logic [ADDR_WIDTH-1:0] br_tgt_c;
   logic [ADDR_WIDTH-1:0] jalr_tgt_c;
   logic [IDX_W-1:0]      upd_idx_c;
   logic [IDX_W-1:0]      look_idx_c;
   logic                  unused_bits;

   assign ready_c    = !valid_q || brif.ready_in;
   assign accept_c   = brif.valid_in && ready_c;
   assign eq_c       = (brif.rs1_data_in == brif.rs2_data_in);
   assign lt_s_c     = ($signed(brif.rs1_data_in) < $signed(brif.rs2_data_in));
   assign lt_u_c     = (brif.rs1_data_in < brif.rs2_data_in);
   assign seq_pc_c   = brif.pc_in + ADDR_WIDTH'(4);
   assign br_tgt_c   = brif.pc_in + brif.imm_in;
   assign jalr_tgt_c = (brif.rs1_data_in[ADDR_WIDTH-1:0] + brif.imm_in) & ~ADDR_WIDTH'(1);
   assign upd_idx_c  = brif.pc_in[IDX_W+1:2];
   assign look_idx_c = brif.bht_pc_in[IDX_W+1:2];
   assign mispred_c  = taken_c ^ brif.pred_taken_in;
   assign unused_bits = ^{brif.bht_pc_in[ADDR_WIDTH-1:IDX_W+2], brif.bht_pc_in[1:0]};

   // uOP decode; anything outside the branch unit or unknown resolves not-taken
   always_comb begin
      is_cond_c = 1'b0;
      is_jump_c = 1'b0;
      is_jalr_c = 1'b0;
      taken_c   = 1'b0;
      if (brif.sel_in == SEL_BRU) begin
         case (brif.uop_in)
            UOP_BEQ:  begin is_cond_c = 1'b1; taken_c = eq_c;    end
            UOP_BNE:  begin is_cond_c = 1'b1; taken_c = !eq_c;   end
            UOP_BLT:  begin is_cond_c = 1'b1; taken_c = lt_s_c;  end
            UOP_BGE:  begin is_cond_c = 1'b1; taken_c = !lt_s_c; end
            UOP_BLTU: begin is_cond_c = 1'b1; taken_c = lt_u_c;  end
            UOP_BGEU: begin is_cond_c = 1'b1; taken_c = !lt_u_c; end
            UOP_JAL:  begin is_jump_c = 1'b1; taken_c = 1'b1;    end
            UOP_JALR: begin is_jump_c = 1'b1; is_jalr_c = 1'b1; taken_c = 1'b1; end
            default:  ;
         endcase
      end
   end

   // next-state: result register, statistics and BHT all advance only on accept
   always_comb begin
      valid_d       = valid_q;
      sel_d         = sel_q;
      target_d      = target_q;
      link_d        = link_q;
      mispred_d     = mispred_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      bht_d         = bht_q;
      if (ready_c) begin
         valid_d = brif.valid_in;
      end
      if (accept_c) begin
         sel_d     = taken_c ? MUX_TAKEN : MUX_SEQ;
         target_d  = !taken_c ? seq_pc_c : (is_jalr_c ? jalr_tgt_c : br_tgt_c);
         link_d    = is_jump_c ? seq_pc_c : '0;
         mispred_d = mispred_c;
         if (is_cond_c && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
         end
         if (mispred_c && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
         end
         if (is_cond_c) begin
            if (taken_c && (bht_q[upd_idx_c] != 2'b11)) begin
               bht_d[upd_idx_c] = bht_q[upd_idx_c] + 2'd1;
            end else if (!taken_c && (bht_q[upd_idx_c] != 2'b00)) begin
               bht_d[upd_idx_c] = bht_q[upd_idx_c] - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q       <= 1'b0;
         sel_q         <= MUX_SEQ;
         target_q      <= '0;
         link_q        <= '0;
         mispred_q     <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= CTR_INIT;
         end
      end else begin
         valid_q       <= valid_d;
         sel_q         <= sel_d;
         target_q      <= target_d;
         link_q        <= link_d;
         mispred_q     <= mispred_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         bht_q         <= bht_d;
      end
   end

   assign brif.ready_out          = ready_c;
   assign brif.valid_out          = valid_q;
   assign brif.pc_mux_sel_out     = sel_q;
   assign brif.target_out         = target_q;
   assign brif.link_out           = link_q;
   assign brif.mispredict_out     = mispred_q;
   assign brif.branch_cnt_out     = branch_cnt_q;
   assign brif.mispredict_cnt_out = mispred_cnt_q;
   // lookup sees the pre-update array; no same-cycle bypass
   assign brif.bht_taken_out      = bht_q[look_idx_c][1];

endmodule

// File: tb/tb_branch_resolver_unit.sv
// Scoreboard bench for branch_resolver_unit: a reference model predicts each
// accepted operation's result, BHT state and statistics.
module tb_branch_resolver_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned CW = 16;
   localparam int unsigned NB = 16;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] target;
      logic [31:0] link;
      logic        mis;
      logic        taken;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   exp_t q[$];
   logic [1:0]  bht_m [NB];
   logic [15:0] bcnt_m;
   logic [15:0] mcnt_m;

   branch_resolver_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bif ();

   branch_resolver_unit #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BHT_ENTRIES(NB), .CNT_WIDTH(CW)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .brif     (bif)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_result(input string t, input logic [1:0] sel, input logic [31:0] tgt,
                               input logic [31:0] lnk, input logic mis);
      check_val({t, "_valid"},  32'(bif.valid_out), 32'd1);
      check_val({t, "_sel"},    32'(bif.pc_mux_sel_out), 32'(sel));
      check_val({t, "_target"}, bif.target_out, tgt);
      check_val({t, "_link"},   bif.link_out, lnk);
      check_val({t, "_mis"},    32'(bif.mispredict_out), 32'(mis));
   endtask

   function automatic void predict(input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [2:0] sel, input logic [3:0] uop,
                                   input logic pred, output exp_t e, output logic cond);
      logic [31:0] tgt;
      logic        tk;
      tk = 1'b0; cond = 1'b0; tgt = pc + imm; e.link = 32'd0;
      if (sel == 3'b011) begin
         case (uop)
            4'd0: begin cond = 1'b1; tk = (rs1 == rs2); end
            4'd1: begin cond = 1'b1; tk = (rs1 != rs2); end
            4'd4: begin cond = 1'b1; tk = ($signed(rs1) <  $signed(rs2)); end
            4'd5: begin cond = 1'b1; tk = ($signed(rs1) >= $signed(rs2)); end
            4'd6: begin cond = 1'b1; tk = (rs1 <  rs2); end
            4'd7: begin cond = 1'b1; tk = (rs1 >= rs2); end
            4'd8: begin tk = 1'b1; e.link = pc + 32'd4; end
            4'd9: begin tk = 1'b1; e.link = pc + 32'd4; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            default: ;
         endcase
      end
      e.taken  = tk;
      e.sel    = tk ? 2'b01 : 2'b10;
      e.target = tk ? tgt : pc + 32'd4;
      e.mis    = tk ^ pred;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) bht_m[i] = 2'b01;
      bcnt_m = 16'd0;
      mcnt_m = 16'd0;
      q.delete();
   endtask

   // Scoreboard monitor: check held result, then model any acceptance at the coming edge
   always @(negedge clk) begin : mon
      exp_t e;
      logic cond;
      logic acc;
      int   idx;
      if (rst_n && mon_en) begin
         acc = bif.valid_in && ((q.size() == 0) || bif.ready_in);
         check_val("mon_valid_out", 32'(bif.valid_out), 32'(q.size() != 0));
         check_val("mon_ready_out", 32'(bif.ready_out), 32'((q.size() == 0) || bif.ready_in));
         check_val("mon_branch_cnt", 32'(bif.branch_cnt_out), 32'(bcnt_m));
         check_val("mon_mispred_cnt", 32'(bif.mispredict_cnt_out), 32'(mcnt_m));
         check_val("mon_bht_taken", 32'(bif.bht_taken_out), 32'(bht_m[bif.bht_pc_in[5:2]][1]));
         if (q.size() != 0) begin
            e = q[0];
            check_val("mon_sel", 32'(bif.pc_mux_sel_out), 32'(e.sel));
            check_val("mon_target", bif.target_out, e.target);
            check_val("mon_link", bif.link_out, e.link);
            check_val("mon_mis", 32'(bif.mispredict_out), 32'(e.mis));
            if (bif.ready_in) void'(q.pop_front());
         end
         if (acc) begin
            predict(bif.pc_in, bif.rs1_data_in, bif.rs2_data_in, bif.imm_in,
                    bif.sel_in, bif.uop_in, bif.pred_taken_in, e, cond);
            q.push_back(e);
            idx = int'(bif.pc_in[5:2]);
            if (cond) begin
               if (bcnt_m != 16'hFFFF) bcnt_m = bcnt_m + 16'd1;
               if (e.taken && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'd1;
               if (!e.taken && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'd1;
            end
            if (e.mis && mcnt_m != 16'hFFFF) mcnt_m = mcnt_m + 16'd1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [2:0] sel, input logic [3:0] uop,
                         input logic pred);
      bif.pc_in = pc; bif.rs1_data_in = rs1; bif.rs2_data_in = rs2; bif.imm_in = imm;
      bif.sel_in = sel; bif.uop_in = uop; bif.pred_taken_in = pred; bif.valid_in = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      bif.valid_in = 1'b0; bif.pc_in = '0; bif.rs1_data_in = '0; bif.rs2_data_in = '0;
      bif.imm_in = '0; bif.sel_in = 3'b0; bif.uop_in = 4'b0; bif.pred_taken_in = 1'b0;
      bif.ready_in = 1'b1; bif.bht_pc_in = '0;
      model_reset();
      #22 rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_valid", 32'(bif.valid_out), 32'd0);
      check_val("rst_sel", 32'(bif.pc_mux_sel_out), 32'd2);
      check_val("rst_target", bif.target_out, 32'd0);
      check_val("rst_link", bif.link_out, 32'd0);
      check_val("rst_mis", 32'(bif.mispredict_out), 32'd0);
      check_val("rst_bcnt", 32'(bif.branch_cnt_out), 32'd0);
      mon_en = 1'b1;

      // JALR: target bit 0 cleared, link = pc+4, BHT index 0 untouched
      step();
      set_op(32'h200, 32'h1003, 32'h0, 32'h4, 3'b011, 4'd9, 1'b1);
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_result("jalr", 2'b01, 32'h1006, 32'h204, 1'b0);
      check_val("jalr_bht0", 32'(bif.bht_taken_out), 32'd0);

      // BEQ taken against a not-taken prediction
      step();
      set_op(32'h100, 32'd5, 32'd5, 32'h20, 3'b011, 4'd0, 1'b0);
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_result("beq", 2'b01, 32'h120, 32'h0, 1'b1);
      check_val("beq_bcnt", 32'(bif.branch_cnt_out), 32'd1);
      check_val("beq_mcnt", 32'(bif.mispredict_cnt_out), 32'd1);

      // BLT then BLTU back-to-back: signed vs unsigned compare
      step();
      set_op(32'h40, 32'hFFFF_FFFF, 32'd1, 32'd8, 3'b011, 4'd4, 1'b0);
      step();
      set_op(32'h40, 32'hFFFF_FFFF, 32'd1, 32'd8, 3'b011, 4'd6, 1'b0);
      @(negedge clk);
      check_result("blt", 2'b01, 32'h48, 32'h0, 1'b1);
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_result("bltu", 2'b10, 32'h44, 32'h0, 1'b0);

      // BHT saturation at index 4
      step();
      bif.bht_pc_in = 32'h10;
      set_op(32'h10, 32'd1, 32'd2, 32'h0, 3'b011, 4'd1, 1'b0);
      @(negedge clk);
      check_val("bht_pre", 32'(bif.bht_taken_out), 32'd0);
      step();
      @(negedge clk);
      check_val("bht_after1", 32'(bif.bht_taken_out), 32'd1);
      step();
      step();
      set_op(32'h10, 32'd3, 32'd3, 32'h0, 3'b011, 4'd1, 1'b0);
      @(negedge clk);
      check_val("bht_sat", 32'(bif.bht_taken_out), 32'd1);
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_val("bht_nt1", 32'(bif.bht_taken_out), 32'd1);
      step();
      bif.valid_in = 1'b1;
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_val("bht_nt2", 32'(bif.bht_taken_out), 32'd0);

      // Stall: result holds, ready_out low, next op accepted on release
      step();
      bif.ready_in = 1'b0;
      set_op(32'h300, 32'd1, 32'd1, 32'h10, 3'b011, 4'd0, 1'b1);
      step();
      set_op(32'h304, 32'd1, 32'd2, 32'h40, 3'b011, 4'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("stall_ready", 32'(bif.ready_out), 32'd0);
         check_result("stall", 2'b01, 32'h310, 32'h0, 1'b0);
         step();
      end
      bif.ready_in = 1'b1;
      @(negedge clk);
      check_val("release_ready", 32'(bif.ready_out), 32'd1);
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_result("release", 2'b01, 32'h344, 32'h0, 1'b1);

      // Random traffic with random backpressure
      for (int n = 0; n < 300; n++) begin
         step();
         bif.valid_in      = ($urandom_range(0, 9) < 7);
         bif.ready_in      = ($urandom_range(0, 3) != 0);
         bif.pc_in         = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 63)) << 2;
         bif.rs1_data_in   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd2;
         bif.rs2_data_in   = ($urandom_range(0, 2) == 0) ? bif.rs1_data_in : 32'($urandom_range(0, 3)) - 32'd2;
         bif.imm_in        = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
         bif.sel_in        = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b011;
         bif.uop_in        = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         bif.pred_taken_in = 1'($urandom_range(0, 1));
         bif.bht_pc_in     = 32'($urandom_range(0, 15)) << 2;
      end
      step();
      bif.valid_in = 1'b0;
      bif.ready_in = 1'b1;
      for (int n = 0; n < 20 && q.size() != 0; n++) step();
      check_val("drain", 32'(q.size()), 32'd0);

      // Asynchronous reset while a stalled result is held
      step();
      bif.ready_in = 1'b0;
      set_op(32'h500, 32'd7, 32'd9, 32'h8, 3'b011, 4'd6, 1'b0);
      step();
      bif.valid_in = 1'b0;
      @(negedge clk);
      check_val("prerst_valid", 32'(bif.valid_out), 32'd1);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_valid", 32'(bif.valid_out), 32'd0);
      check_val("async_rst_sel", 32'(bif.pc_mux_sel_out), 32'd2);
      model_reset();
      #10 rst_n = 1'b1;
      bif.ready_in = 1'b1;
      for (int i = 0; i < NB; i++) begin
         bif.bht_pc_in = 32'(i) << 2;
         #1;
         check_val("rst_bht", 32'(bif.bht_taken_out), 32'd0);
      end
      check_val("rst2_bcnt", 32'(bif.branch_cnt_out), 32'd0);
      check_val("rst2_mcnt", 32'(bif.mispredict_cnt_out), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
